rr_channel_selector: RTL and testbench
======================================

# rr_channel_selector

Parametrised N-channel, WIDTH-bit registered selector with valid/ready handshakes on every input and on the output. It selects one source per cycle, either by an explicit `sel` channel index (fixed mode) or by round-robin arbitration (rotating mode). The chosen beat is captured into a single output register. It sits between multiple producers and one shared consumer, for example several datapath result buses feeding one writeback port. It generalises the 4-to-1 combinational selector to N channels with buffering, backpressure and fairness.

## Interface
- `WIDTH`, 32, data width per channel (1..64)
- `N`, 4, channel count (2..16, power of two)
- `SELW`, $clog2(N), width of the channel index (derived, not overridden)

- `clk`  in  1  rising-edge clock, single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `mode`  in  1  0 = fixed select by `sel`; 1 = round-robin
- `sel`  in  SELW  selected channel in fixed mode; ignored in round-robin mode
- `in_valid`  in  N  per-channel beat-valid
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_ready`  out  N  per-channel accept; at most one bit high per cycle
- `out_valid`  out  1  output register holds a beat
- `out_data`  out  WIDTH  registered data of the held beat
- `out_chan`  out  SELW  source channel of the held beat
- `out_ready`  in  1  consumer accepts the beat when high together with `out_valid`

## Operation
- Internal state: output register (`out_valid`, `out_data`, `out_chan`) plus round-robin pointer `ptr` (SELW bits).
- `load = ~out_valid | out_ready`.
  - When `load` is high, the register may take a new beat this cycle.
  - This allows a full register to be drained and refilled in the same cycle.
- Grant, computed combinationally and only when `load` is high:
  - Fixed mode: grant channel `sel` iff `in_valid[sel]`; other channels are never granted.
  - Round-robin mode: grant the first i with `in_valid[i]=1`, scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1` (mod N).
- `in_ready[i] = load & grant[i]`. A transfer on channel i occurs when `in_valid[i] & in_ready[i]`.
- On a clock edge with a transfer on channel g:
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - Round-robin mode only: `ptr <= (g+1) mod N`, wrapping from N-1 to 0.
- On an edge with `load` high and no transfer: `out_valid <= 0`. `out_data` and `out_chan` keep their old values.
- On an edge with `load` low (held beat, `out_ready=0`): the register and `ptr` are unchanged. `out_data` and `out_chan` stay stable.
- `ptr` is not modified in fixed mode. Switching back to round-robin resumes from the last round-robin pointer.
- `mode` and `sel` are sampled combinationally each cycle. A change affects only the grant of that same cycle; there is no state to flush.
- `sel` values are always in 0..N-1, because N is a power of two.

## Timing
- Reset, asynchronous, takes effect immediately regardless of `clk`:
  - `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`.
  - `in_ready` is all zero for as long as reset is held.
- Reset asserted mid-transfer discards the held beat. The first grant after release uses `ptr=0`.
- Latency: an input accepted at edge k appears on `out_*` immediately after edge k. It is consumed at the first edge ≥ k+1 where `out_ready=1`.
- Throughput: one beat per cycle with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready`, `mode`, `sel`, `in_valid` and `ptr`. It has no combinational dependency on `in_data`.
- Producers must hold `in_valid` and `in_data` until accepted. The block never drops or duplicates a beat.
- Fairness: in round-robin mode with all channels continuously valid and `out_ready=1`, grants cycle 0,1,…,N-1,0,… Each channel waits at most N-1 beats.

## Test plan
- Reset, then N=4, WIDTH=32, mode=1, all in_valid=1, data i = 0xA0+i, out_ready=1 → out_chan sequence 0,1,2,3,0 on consecutive cycles; out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0; in_ready one-hot.
- mode=0, sel=2, in_valid=4'b1011 → no grant, out_valid=0. Then raise in_valid[2] with data 0x55 → out_valid=1, out_chan=2, out_data=0x55 one cycle later.
- Round-robin mode, out_ready=0 after the first beat (chan 0) → out_data/out_chan stable, in_ready=0 throughout. Release out_ready → next grant is chan 1.
- Round-robin mode, only in_valid[3] and in_valid[1] high, ptr=2 → grant 3, then wrap to grant 1, then 3 (ptr wraps 3→0).
- Assert reset while out_valid=1 and out_ready=0 → out_valid, out_data, out_chan drop to 0 immediately (mid-cycle). First post-reset grant with all channels valid is chan 0.
- Round-robin to chan 1, switch to mode=0 (sel=3) for 3 beats, back to mode=1 with all valid → grants resume at chan 2.

Source files
------------

// File: rtl/rr_channel_selector.sv
`default_nettype none
// ============================================================================
// Module   : rr_channel_selector
// Purpose  : N-channel registered selector with valid/ready handshakes,
//            choosing a source either by fixed index or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module rr_channel_selector #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SELW-1:0]      out_chan_q,  out_chan_d;
    logic [SELW-1:0]      ptr_q,       ptr_d;

    logic [WIDTH-1:0]     chan_data [N];
    logic                 load;
    logic                 rr_found;
    logic [SELW-1:0]      rr_idx;
    logic [SELW-1:0]      rr_cand;
    logic                 grant_any;
    logic [SELW-1:0]      grant_idx;
    logic                 transfer;

    generate
        for (genvar i = 0; i < N; i++) begin : g_unpack
            assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    endgenerate

    assign load = ~out_valid_q | out_ready;

    // Scan starts at ptr; the index wraps naturally because N is a power of two.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        rr_cand  = ptr_q;
        for (int k = 0; k < N; k++) begin
            rr_cand = ptr_q + SELW'(k);
            if (!rr_found && in_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant_any = rr_found;
            grant_idx = rr_idx;
        end else begin
            grant_any = in_valid[sel];
            grant_idx = sel;
        end
    end

    assign transfer = load & grant_any;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ready
            assign in_ready[i] = transfer & (grant_idx == SELW'(i)) & ~reset;
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (grant_any) begin
                out_valid_d = 1'b1;
                out_data_d  = chan_data[grant_idx];
                out_chan_d  = grant_idx;
                if (mode) begin
                    ptr_d = grant_idx + SELW'(1);
                end
            end else begin
                // Old data/chan retained; only the valid flag drops.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_channel_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_channel_selector
// Purpose  : Scoreboard bench for rr_channel_selector (N=4, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_channel_selector;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 mode = 1'b1;
    logic [SELW-1:0]      sel = '0;
    logic [N-1:0]         in_valid = '0;
    logic [N*WIDTH-1:0]   in_data = '0;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_ready = 1'b1;

    typedef struct {
        logic [SELW-1:0]  chan;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t sb [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    rr_channel_selector #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    // Expect channel c to be granted this cycle carrying data d.
    task automatic beat(input int c, input logic [WIDTH-1:0] d);
        beat_t b;
        #1;
        chk("in_ready_grant", 64'(in_ready), 64'(4'b0001 << c));
        b.chan = SELW'(c);
        b.data = d;
        sb.push_back(b);
        tick();
    endtask

    // Monitor: a beat is consumed whenever out_valid & out_ready ahead of an edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got chan %0d data 0x%0h expected none", out_chan, out_data);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("sb_chan", 64'(out_chan), 64'(e.chan));
                chk("sb_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) set_data(i, 32'hA0 + i);
        in_valid = 4'b1111;
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data",  64'(out_data),  0);
        chk("rst_out_chan",  64'(out_chan),  0);
        chk("rst_in_ready",  64'(in_ready),  0);
        tick();
        tick();
        reset = 1'b0;

        // Round-robin with all channels valid: 0,1,2,3,0
        beat(0, 32'hA0);
        beat(1, 32'hA1);
        beat(2, 32'hA2);
        beat(3, 32'hA3);
        beat(0, 32'hA0);
        in_valid = 4'b0000;
        tick();
        chk("drain_out_valid", 64'(out_valid), 0);

        // Fixed mode, selected channel idle
        mode = 1'b0;
        sel = 2'd2;
        in_valid = 4'b1011;
        #1;
        chk("fixed_idle_ready", 64'(in_ready), 0);
        tick();
        chk("fixed_idle_valid", 64'(out_valid), 0);
        set_data(2, 32'h55);
        in_valid = 4'b1111;
        beat(2, 32'h55);
        chk("fixed_out_valid", 64'(out_valid), 1);
        chk("fixed_out_chan",  64'(out_chan),  2);
        chk("fixed_out_data",  64'(out_data),  32'h55);
        in_valid = 4'b0000;
        set_data(2, 32'hA2);
        tick();

        // Reset while a beat is held (ptr is 1 here, so chan 1 is taken)
        mode = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b0;
        beat(1, 32'hA1);
        chk("held_in_ready", 64'(in_ready), 0);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 0);
        chk("midrst_out_data",  64'(out_data),  0);
        chk("midrst_out_chan",  64'(out_chan),  0);
        chk("midrst_in_ready",  64'(in_ready),  0);
        tick();
        reset = 1'b0;

        // Post-reset grant from ptr=0, then stall
        beat(0, 32'hA0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", 64'(out_valid), 1);
            chk("stall_chan",  64'(out_chan),  0);
            chk("stall_data",  64'(out_data),  32'hA0);
            chk("stall_ready", 64'(in_ready),  0);
            tick();
        end
        out_ready = 1'b1;
        beat(1, 32'hA1);
        in_valid = 4'b0000;
        tick();

        // ptr=2, only channels 3 and 1 valid: 3, 1, 3
        in_valid = 4'b1010;
        beat(3, 32'hA3);
        beat(1, 32'hA1);
        beat(3, 32'hA3);
        in_valid = 4'b0000;
        tick();

        // RR to chan 1, three fixed beats on chan 3, RR resumes at 2
        in_valid = 4'b0010;
        beat(1, 32'hA1);
        mode = 1'b0;
        sel = 2'd3;
        in_valid = 4'b1111;
        for (int b = 0; b < 3; b++) begin
            set_data(3, 32'h30 + b);
            beat(3, 32'h30 + b);
        end
        mode = 1'b1;
        set_data(3, 32'hA3);
        beat(2, 32'hA2);
        beat(3, 32'hA3);
        in_valid = 4'b0000;
        tick();
        tick();
        chk("final_out_valid", 64'(out_valid), 0);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
